// File: rtl/cpm_pkg.sv
// Shared types and constants for the clock period meter.
package cpm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } cpm_state_t;

    // Allowed |2*high - period| for the duty check; absorbs half-cycle
    // quantisation of odd-ratio 50% clocks.
    localparam int unsigned DUTY_TOL = 2;

    // Derived sizes depend on module parameters, so they are exposed as
    // helpers that each instance turns into its own localparams.
    function automatic int unsigned n_avg(input int unsigned avg_log2);
        return 32'd1 << avg_log2;
    endfunction

    function automatic int unsigned sum_w(input int unsigned cnt_w, input int unsigned avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/cpm_sync_edge.sv
// Two-flop synchronizer plus history flop; emits the synchronized level and
// a one-cycle rising-edge strobe. Fixed 2-cycle latency from sig_in.
module cpm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic lvl,
    output logic rise
);

    logic s1, s2, s3;

    // Synchronizer chain and edge-history flop, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// Clock period meter: averages the period (and optionally the high time) of a
// slow square wave over 2^AVG_LOG2 periods, in clk cycles, and flags lock
// against an expected period.
// Optional feature macro: CPM_DUTY_EN (high-time accumulator and duty check).
module clk_period_meter
    import cpm_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TOL      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic [CNT_W-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             lock,
    output logic             duty_ok,
    output logic             timeout
);

    localparam int unsigned N_AVG = n_avg(AVG_LOG2);
    localparam int unsigned SUM_W = sum_w(CNT_W, AVG_LOG2);
    localparam int unsigned EDG_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] IDLE_TC = {{(CNT_W-1){1'b1}}, 1'b0};

    cpm_state_t state_q, state_d;

    logic             rise;
    logic [SUM_W-1:0] cyc_q;
    logic [EDG_W-1:0] edges_q;
    logic [CNT_W-1:0] idle_q;
    logic [CNT_W-1:0] expected_q;
    logic [CNT_W-1:0] period_q;
    logic             lock_q;
    logic             timeout_q;

    logic             last_rise;
    logic             tmo_hit;
    logic [SUM_W-1:0] sum_fin;
    logic [SUM_W-1:0] quot;
    logic             ovf;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] diff;
    logic             lock_nxt;

`ifdef CPM_DUTY_EN
    logic sig_lvl;

    cpm_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .lvl    (sig_lvl),
        .rise   (rise)
    );
`else
    logic sig_lvl_unused;

    cpm_sync_edge u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .lvl    (sig_lvl_unused),
        .rise   (rise)
    );
`endif

    // Edge-count terminal, no-edge timeout, and averaged result with saturation.
    always_comb begin
        last_rise  = rise && (edges_q == EDG_W'(N_AVG - 1));
        tmo_hit    = ((state_q == ARM) || (state_q == MEAS)) && (idle_q == IDLE_TC) && !rise;
        sum_fin    = cyc_q + SUM_W'(1);
        quot       = sum_fin >> AVG_LOG2;
        ovf        = |(quot >> CNT_W);
        period_nxt = ovf ? '1 : quot[CNT_W-1:0];
        diff       = (period_nxt >= expected_q) ? (period_nxt - expected_q)
                                                : (expected_q - period_nxt);
        lock_nxt   = !ovf && (diff <= CNT_W'(TOL));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; a rise always beats the timeout terminal count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = ARM;
            ARM: begin
                if (rise)         state_d = MEAS;
                else if (tmo_hit) state_d = IDLE;
            end
            MEAS: begin
                if (last_rise)    state_d = DONE;
                else if (tmo_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        busy = (state_q == ARM) || (state_q == MEAS);
        done = (state_q == DONE);
    end

    // Measurement datapath. Results register on the edge into DONE so the
    // done pulse and the new values are visible in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q      <= '0;
            edges_q    <= '0;
            idle_q     <= '0;
            expected_q <= '0;
            period_q   <= '0;
            lock_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        timeout_q  <= 1'b0;
                        idle_q     <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cyc_q   <= '0;
                        edges_q <= '0;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + CNT_W'(1);
                        if (tmo_hit) timeout_q <= 1'b1;
                    end
                end
                MEAS: begin
                    cyc_q <= cyc_q + SUM_W'(1);
                    if (rise) begin
                        edges_q <= edges_q + EDG_W'(1);
                        idle_q  <= '0;
                        if (last_rise) begin
                            period_q <= period_nxt;
                            lock_q   <= lock_nxt;
                        end
                    end else begin
                        idle_q <= idle_q + CNT_W'(1);
                        if (tmo_hit) timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign period  = period_q;
    assign lock    = lock_q;
    assign timeout = timeout_q;

`ifdef CPM_DUTY_EN
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_fin;
    logic [SUM_W-1:0] hquot;
    logic [CNT_W-1:0] high_nxt;
    logic [CNT_W:0]   dbl;
    logic [CNT_W:0]   pext;
    logic [CNT_W:0]   ddiff;
    logic             duty_nxt;
    logic [CNT_W-1:0] high_q;
    logic             duty_q;

    // Averaged high time and |2*high - period| duty check.
    always_comb begin
        acc_fin  = acc_q + SUM_W'(sig_lvl);
        hquot    = acc_fin >> AVG_LOG2;
        high_nxt = (|(hquot >> CNT_W)) ? '1 : hquot[CNT_W-1:0];
        dbl      = {high_nxt, 1'b0};
        pext     = {1'b0, period_nxt};
        ddiff    = (dbl >= pext) ? (dbl - pext) : (pext - dbl);
        duty_nxt = !ovf && (ddiff <= (CNT_W+1)'(DUTY_TOL));
    end

    // High-time accumulator over the same window as the cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            high_q <= '0;
            duty_q <= 1'b0;
        end else if ((state_q == ARM) && rise) begin
            acc_q <= '0;
        end else if (state_q == MEAS) begin
            acc_q <= acc_fin;
            if (last_rise) begin
                high_q <= high_nxt;
                duty_q <= duty_nxt;
            end
        end
    end

    assign high_cnt = high_q;
    assign duty_ok  = duty_q;
`else
    assign high_cnt = '0;
    assign duty_ok  = 1'b0;
`endif

endmodule
